// File: rtl/dmac_pkg.sv
// Shared definitions for the DMA channel FIFO: controller state encoding
// and default geometry.
package dmac_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH      = 8;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    NO_OP  = 3'd1,
    WRITE  = 3'd2,
    WR_ERR = 3'd3,
    READ   = 3'd4,
    RD_ERR = 3'd5,
    BOTH   = 3'd6
  } state_t;

endpackage

// File: rtl/dmac_fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH registers with a one-hot per-entry write
// enable and an asynchronous read mux. Contents are deliberately not reset.
module dmac_fifo_mem
  import dmac_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      entry_we;

  always_comb begin
    entry_we          = '0;
    entry_we[wr_addr] = wr_en;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_we[i]) begin
        mem[i] <= din;
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dmac_fifo.sv
// DMA channel FIFO controller: registered FSM, pointers, count and dout.
// Define DMAC_FIFO_ERR_EN to add sticky wr_err/rd_err outputs.
module dmac_fifo
  import dmac_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  wr_ack,
  output logic                  rd_ack,
  output logic [$clog2(DEPTH):0] data_count
`ifdef DMAC_FIFO_ERR_EN
  ,
  output logic                  wr_err,
  output logic                  rd_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  state_t                state_q, state_d;
  logic [AW-1:0]         head_q, tail_q;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  wr_ok, rd_ok;

  // Acceptance uses the pre-edge count, so a full FIFO never passes a write through.
  always_comb begin
    wr_ok   = wr_en && (count_q != FULL_COUNT);
    rd_ok   = rd_en && (count_q != '0);
    state_d = NO_OP;
    if (wr_ok && rd_ok)  state_d = BOTH;
    else if (wr_ok)      state_d = WRITE;
    else if (rd_ok)      state_d = READ;
    else if (wr_en)      state_d = WR_ERR;
    else if (rd_en)      state_d = RD_ERR;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      dout    <= '0;
    end else begin
      state_q <= state_d;
      if (wr_ok) head_q <= head_q + AW'(1);
      if (rd_ok) begin
        tail_q <= tail_q + AW'(1);
        dout   <= mem_rdata;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign full       = (count_q == FULL_COUNT);
  assign empty      = (count_q == '0);
  assign data_count = count_q;
  assign wr_ack     = (state_q == WRITE) || (state_q == BOTH);
  assign rd_ack     = (state_q == READ)  || (state_q == BOTH);

`ifdef DMAC_FIFO_ERR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_err <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      if (wr_en && !wr_ok) wr_err <= 1'b1;
      if (rd_en && !rd_ok) rd_err <= 1'b1;
    end
  end
`endif

  dmac_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (head_q),
    .din     (din),
    .rd_addr (tail_q),
    .rd_data (mem_rdata)
  );

endmodule
